delta_ram_ctrl: RTL and testbench

Access controller for the single-port delta RAM wrapper. Two requesters share the one physical port: a write requester (delta fill) and a read requester (PE delta fetch). The block arbitrates between them with write priority and bounded read starvation. It registers read data and, optionally, clears the whole RAM after reset. It sits between the fill/fetch logic and the RAM wrapper's `addr_r`/`addr_w`/`read_en`/`write_en`/`data_in`/`data_out` pins.

---
 rtl/delta_ram_ctrl_if.sv | 35 +++
 rtl/delta_ram_ctrl.sv | 136 +++++++++++++
 tb/tb_delta_ram_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/delta_ram_ctrl_if.sv
// Request/grant and RAM-side signal bundle for delta_ram_ctrl.
// master = requesters plus RAM wrapper; slave = the controller.
interface delta_ram_ctrl_if #(
    parameter int unsigned SRAM_DEPTH_BIT = 6,
    parameter int unsigned SRAM_WIDTH     = 28
);
    logic                      wr_req;
    logic [SRAM_DEPTH_BIT-1:0] wr_addr;
    logic [SRAM_WIDTH-1:0]     wr_data;
    logic                      wr_gnt;
    logic                      rd_req;
    logic [SRAM_DEPTH_BIT-1:0] rd_addr;
    logic                      rd_gnt;
    logic                      rd_valid;
    logic [SRAM_WIDTH-1:0]     rd_data;
    logic                      init_done;
    logic [SRAM_DEPTH_BIT-1:0] ram_addr_r;
    logic [SRAM_DEPTH_BIT-1:0] ram_addr_w;
    logic                      ram_read_en;
    logic                      ram_write_en;
    logic [SRAM_WIDTH-1:0]     ram_data_in;
    logic [SRAM_WIDTH-1:0]     ram_data_out;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_data_out,
        input  wr_gnt, rd_gnt, rd_valid, rd_data, init_done,
        input  ram_addr_r, ram_addr_w, ram_read_en, ram_write_en, ram_data_in
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_data_out,
        output wr_gnt, rd_gnt, rd_valid, rd_data, init_done,
        output ram_addr_r, ram_addr_w, ram_read_en, ram_write_en, ram_data_in
    );
endinterface

// File: rtl/delta_ram_ctrl.sv
// Single-port delta RAM access controller: write-priority arbitration with bounded read starvation.
// Define DELTA_RAM_CLEAR_EN to zero the whole RAM after every reset before serving requests.
module delta_ram_ctrl #(
    parameter int unsigned SRAM_DEPTH_BIT = 6,
    parameter int unsigned SRAM_WIDTH     = 28,
    parameter int unsigned STARVE_MAX     = 4
) (
    input logic             clk,
    input logic             rst_n,
    delta_ram_ctrl_if.slave bus
);
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic                  w_run;
    logic                  w_wr_gnt;
    logic                  w_rd_gnt;
    logic [3:0]            r_starve_cnt;
    logic [3:0]            w_starve_cnt_d;
    logic                  r_rd_pend;
    logic                  r_rd_valid;
    logic [SRAM_WIDTH-1:0] r_rd_data;
    logic                  w_clr_we;
    logic [SRAM_DEPTH_BIT-1:0] w_clr_addr;

`ifdef DELTA_RAM_CLEAR_EN
    typedef enum logic [0:0] {StInit, StRun} state_e;

    localparam logic [SRAM_DEPTH_BIT-1:0] ClrLast = '1;
    localparam logic [SRAM_DEPTH_BIT-1:0] AddrOne = {{(SRAM_DEPTH_BIT-1){1'b0}}, 1'b1};

    state_e                    r_state;
    state_e                    w_state_d;
    logic [SRAM_DEPTH_BIT-1:0] r_clr_addr;
    logic [SRAM_DEPTH_BIT-1:0] w_clr_addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StInit;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_d;
            r_clr_addr <= w_clr_addr_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_clr_addr_d = r_clr_addr;
        w_clr_we     = 1'b0;
        unique case (r_state)
            StInit: begin
                // Keep the RAM port quiet while reset is still asserted.
                w_clr_we     = rst_n;
                w_clr_addr_d = r_clr_addr + AddrOne;
                if (r_clr_addr == ClrLast) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_state_d = StRun;
            end
            default: begin
                w_state_d = StInit;
            end
        endcase
    end

    assign w_run      = (r_state == StRun);
    assign w_clr_addr = r_clr_addr;
`else
    logic r_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign w_run      = r_run;
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
`endif

    // Write wins a conflict unless the read has already been denied StarveMax times in a row.
    always_comb begin
        w_wr_gnt = w_run & bus.wr_req & (~bus.rd_req | (r_starve_cnt != StarveMax));
        w_rd_gnt = w_run & bus.rd_req & (~bus.wr_req | (r_starve_cnt == StarveMax));
    end

    always_comb begin
        w_starve_cnt_d = r_starve_cnt;
        if (w_rd_gnt) begin
            w_starve_cnt_d = '0;
        end else if (bus.rd_req && (r_starve_cnt != StarveMax)) begin
            w_starve_cnt_d = r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_rd_pend    <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_starve_cnt <= w_starve_cnt_d;
            r_rd_pend    <= w_rd_gnt;
            r_rd_valid   <= r_rd_pend;
            if (r_rd_pend) begin
                r_rd_data <= bus.ram_data_out;
            end
        end
    end

    always_comb begin
        bus.ram_write_en = w_wr_gnt;
        bus.ram_addr_w   = w_wr_gnt ? bus.wr_addr : '0;
        bus.ram_data_in  = w_wr_gnt ? bus.wr_data : '0;
        if (w_clr_we) begin
            bus.ram_write_en = 1'b1;
            bus.ram_addr_w   = w_clr_addr;
            bus.ram_data_in  = '0;
        end
        bus.ram_read_en  = w_rd_gnt;
        bus.ram_addr_r   = w_rd_gnt ? bus.rd_addr : '0;
    end

    assign bus.wr_gnt    = w_wr_gnt;
    assign bus.rd_gnt    = w_rd_gnt;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
    assign bus.init_done = w_run;

endmodule

// File: tb/tb_delta_ram_ctrl.sv
// Scoreboard bench for delta_ram_ctrl; behavioural RAM plus a reference memory built from stimulus.
module tb_delta_ram_ctrl;
    localparam int AW    = 6;
    localparam int DW    = 28;
    localparam int DEPTH = 64;
`ifdef DELTA_RAM_CLEAR_EN
    localparam int ExpLo = 64;
    localparam int ExpZw = 64;
`else
    localparam int ExpLo = 1;
    localparam int ExpZw = 0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    exp_t sb [$];
    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;

    logic s_wr_gnt, s_rd_gnt, s_rd_valid, s_init_done, s_re, s_we;
    logic [DW-1:0] s_rd_data, s_din;
    logic [AW-1:0] s_addr_r, s_addr_w;

    delta_ram_ctrl_if #(.SRAM_DEPTH_BIT(AW), .SRAM_WIDTH(DW)) bus ();

    delta_ram_ctrl #(.SRAM_DEPTH_BIT(AW), .SRAM_WIDTH(DW), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.ram_read_en) bus.ram_data_out <= mem[bus.ram_addr_r];
        if (bus.ram_write_en) mem[bus.ram_addr_w] = bus.ram_data_in;
    end

    function automatic logic [DW-1:0] pat(int i);
        logic [31:0] v;
        v = 32'h0A5A5A5 ^ (i * 32'h10101);
        return v[DW-1:0];
    endfunction

    task automatic cyc();
        exp_t e;
        @(negedge clk);
        cyc_n++;
        s_wr_gnt = bus.wr_gnt;       s_rd_gnt = bus.rd_gnt;
        s_rd_valid = bus.rd_valid;   s_init_done = bus.init_done;
        s_re = bus.ram_read_en;      s_we = bus.ram_write_en;
        s_rd_data = bus.rd_data;     s_din = bus.ram_data_in;
        s_addr_r = bus.ram_addr_r;   s_addr_w = bus.ram_addr_w;
        if (s_rd_gnt) begin
            e.data = ref_mem[bus.rd_addr];
            e.cyc  = cyc_n;
            sb.push_back(e);
        end
        if (s_wr_gnt) ref_mem[bus.wr_addr] = bus.wr_data;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ref();
`ifdef DELTA_RAM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
    endtask

    task automatic test_reset();
        int n_lo, n_zw, bad;
        bit done;
        rst_n = 1'b0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = pat(i);
            ref_mem[i] = pat(i);
        end
        clear_ref();
        repeat (2) @(posedge clk);
        #1;
        cyc();
        n_vec++;
        if ({s_wr_gnt, s_rd_gnt, s_rd_valid, s_init_done, s_re, s_we, s_rd_data, s_din,
             s_addr_r, s_addr_w} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got gnt=%b%b vld=%b done=%b re=%b we=%b rd=%h din=%h, required all 0",
                     s_wr_gnt, s_rd_gnt, s_rd_valid, s_init_done, s_re, s_we, s_rd_data, s_din);
        end
        bus.rd_req = 1'b1; bus.rd_addr = 6'd9;
        cyc();
        n_vec++;
        if (s_rd_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_grant: got rd_gnt=%b, required 0", s_rd_gnt);
        end
        rst_n = 1'b1;
        n_lo = 0; n_zw = 0; bad = 0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            cyc();
            if (s_init_done) done = 1'b1;
            else begin
                n_lo++;
                if (s_rd_gnt || s_wr_gnt) bad++;
                if (s_we && s_din == '0 && int'(s_addr_w) == n_lo - 1) n_zw++;
            end
        end
        n_vec++;
        if (!done || n_lo != ExpLo) begin
            n_err++;
            $display("FAIL init_latency: got %0d cycles before init_done (done=%b), required %0d",
                     n_lo, done, ExpLo);
        end
        n_vec++;
        if (n_zw != ExpZw) begin
            n_err++;
            $display("FAIL init_clear_writes: got %0d zero writes, required %0d", n_zw, ExpZw);
        end
        n_vec++;
        if (bad != 0 || s_rd_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL init_hold_read: got %0d early grants, first-run rd_gnt=%b, required 0 and 1",
                     bad, s_rd_gnt);
        end
        bus.rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (s_rd_valid) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL rd_unexpected: got rd_valid=1 data=%h, required none", s_rd_data);
                end else begin
                    exp_t e = sb.pop_front();
                    if (s_rd_data !== e.data || cyc_n - e.cyc != 2) begin
                        n_err++;
                        $display("FAIL init_read: got %h latency %0d, required %h latency 2",
                                 s_rd_data, cyc_n - e.cyc, e.data);
                    end
                end
            end
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL init_read_missing: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_write_read();
        bus.wr_req = 1'b1; bus.wr_addr = 6'd5; bus.wr_data = 28'h0ABCDEF;
        cyc();
        n_vec++;
        if (s_wr_gnt !== 1'b1 || s_we !== 1'b1 || s_addr_w !== 6'd5 || s_din !== 28'h0ABCDEF) begin
            n_err++;
            $display("FAIL write_port: got gnt=%b we=%b addr=%0d din=%h, required 1 1 5 0abcdef",
                     s_wr_gnt, s_we, s_addr_w, s_din);
        end
        bus.wr_req = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 6'd5;
        cyc();
        n_vec++;
        if (s_rd_gnt !== 1'b1 || s_re !== 1'b1 || s_addr_r !== 6'd5 || s_we !== 1'b0) begin
            n_err++;
            $display("FAIL read_port: got gnt=%b re=%b addr=%0d we=%b, required 1 1 5 0",
                     s_rd_gnt, s_re, s_addr_r, s_we);
        end
        bus.rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (s_rd_valid) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL rd_unexpected: got rd_valid=1 data=%h, required none", s_rd_data);
                end else begin
                    exp_t e = sb.pop_front();
                    if (s_rd_data !== e.data || cyc_n - e.cyc != 2 || e.data !== 28'h0ABCDEF) begin
                        n_err++;
                        $display("FAIL write_read: got %h latency %0d, required 0abcdef latency 2",
                                 s_rd_data, cyc_n - e.cyc);
                    end
                end
            end
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL write_read_missing: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int n_valid = 0;
        int bad = 0;
        bus.wr_req = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus.wr_addr = 6'(a); bus.wr_data = 28'(a);
            cyc();
            if (!s_wr_gnt) bad++;
        end
        bus.wr_req = 1'b0; bus.rd_req = 1'b1;
        for (int a = 0; a < 12; a++) begin
            bus.rd_addr = 6'(a);
            if (a == 8) bus.rd_req = 1'b0;
            cyc();
            if (a < 8 && !s_rd_gnt) bad++;
            if (s_rd_valid) begin
                n_vec++;
                n_valid++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL rd_unexpected: got rd_valid=1 data=%h, required none", s_rd_data);
                end else begin
                    exp_t e = sb.pop_front();
                    if (s_rd_data !== e.data || cyc_n - e.cyc != 2 || e.data !== 28'(n_valid - 1)) begin
                        n_err++;
                        $display("FAIL b2b_read: got %h latency %0d, required %h latency 2",
                                 s_rd_data, cyc_n - e.cyc, n_valid - 1);
                    end
                end
            end
        end
        n_vec++;
        if (bad != 0 || n_valid != 8 || sb.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count: got %0d missed grants, %0d pulses, %0d pending, required 0 8 0",
                     bad, n_valid, sb.size());
        end
    endtask

    task automatic test_raw();
        int n_valid = 0;
        bus.wr_req = 1'b1; bus.wr_addr = 6'd3; bus.wr_data = 28'h1;
        cyc();
        bus.wr_req = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 6'd3;
        cyc();
        bus.rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (s_rd_valid) begin
                n_vec++;
                n_valid++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL rd_unexpected: got rd_valid=1 data=%h, required none", s_rd_data);
                end else begin
                    exp_t e = sb.pop_front();
                    if (s_rd_data !== e.data || e.data !== 28'h1) begin
                        n_err++;
                        $display("FAIL raw_read: got %h, required 1", s_rd_data);
                    end
                end
            end
        end
        n_vec++;
        if (n_valid != 1) begin
            n_err++; $display("FAIL raw_count: got %0d pulses, required 1", n_valid);
        end
    endtask

    task automatic test_starve();
        int k = 0;
        bus.wr_req = 1'b1; bus.wr_addr = 6'd20; bus.wr_data = 28'h100;
        bus.rd_req = 1'b1; bus.rd_addr = 6'd3;
        for (int i = 0; i < 24; i++) begin
            bit exp_rd;
            if (i == 20) begin
                bus.wr_req = 1'b0; bus.rd_req = 1'b0;
            end
            exp_rd = (i < 20) && (i % 5 == 4);
            cyc();
            if (i < 20) begin
                n_vec++;
                if (s_rd_gnt !== exp_rd || s_wr_gnt !== !exp_rd || (s_re & s_we)) begin
                    n_err++;
                    $display("FAIL starve_cycle%0d: got wr_gnt=%b rd_gnt=%b re=%b we=%b, required wr=%b rd=%b",
                             i + 1, s_wr_gnt, s_rd_gnt, s_re, s_we, !exp_rd, exp_rd);
                end
                if (s_wr_gnt) begin
                    k++;
                    bus.wr_data = 28'h100 + 28'(k);
                end
            end
            if (s_rd_valid) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL rd_unexpected: got rd_valid=1 data=%h, required none", s_rd_data);
                end else begin
                    exp_t e = sb.pop_front();
                    if (s_rd_data !== e.data || cyc_n - e.cyc != 2) begin
                        n_err++;
                        $display("FAIL starve_read: got %h latency %0d, required %h latency 2",
                                 s_rd_data, cyc_n - e.cyc, e.data);
                    end
                end
            end
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL starve_missing: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int n_lo = 0;
        bit done = 1'b0;
        bus.rd_req = 1'b1; bus.rd_addr = 6'd7;
        cyc();
        bus.wr_req = 1'b1; bus.wr_addr = 6'd30; bus.wr_data = 28'h0DEAD00;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        clear_ref();
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_vec++;
            if ({s_wr_gnt, s_rd_gnt, s_rd_valid, s_init_done, s_re, s_we, s_rd_data, s_din,
                 s_addr_r, s_addr_w} !== '0) begin
                n_err++;
                $display("FAIL midreset_outputs: got gnt=%b%b vld=%b done=%b re=%b we=%b rd=%h, required all 0",
                         s_wr_gnt, s_rd_gnt, s_rd_valid, s_init_done, s_re, s_we, s_rd_data);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            cyc();
            if (s_init_done) done = 1'b1;
            else n_lo++;
            n_vec++;
            if (s_rd_valid !== 1'b0) begin
                n_err++; $display("FAIL midreset_stale_valid: got rd_valid=1, required 0");
            end
        end
        n_vec++;
        if (!done || n_lo != ExpLo) begin
            n_err++;
            $display("FAIL midreset_init: got %0d cycles (done=%b), required %0d", n_lo, done, ExpLo);
        end
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bit exp_rd;
            if (i == 5) begin
                bus.wr_req = 1'b0; bus.rd_req = 1'b0;
            end
            exp_rd = (i == 4);
            cyc();
            if (i < 5) begin
                n_vec++;
                if (s_rd_gnt !== exp_rd || s_wr_gnt !== !exp_rd) begin
                    n_err++;
                    $display("FAIL midreset_starve%0d: got wr_gnt=%b rd_gnt=%b, required wr=%b rd=%b",
                             i + 1, s_wr_gnt, s_rd_gnt, !exp_rd, exp_rd);
                end
            end
            if (s_rd_valid) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL rd_unexpected: got rd_valid=1 data=%h, required none", s_rd_data);
                end else begin
                    exp_t e = sb.pop_front();
                    if (s_rd_data !== e.data || cyc_n - e.cyc != 2) begin
                        n_err++;
                        $display("FAIL midreset_read: got %h latency %0d, required %h latency 2",
                                 s_rd_data, cyc_n - e.cyc, e.data);
                    end
                end
            end
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL midreset_missing: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_raw();
        test_starve();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
